// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/busy/done handshake and data bus of the binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
);
  logic                  start;
  logic [IN_WIDTH-1:0]   bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave  (input start, bin_in, output busy, done, bcd_out);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble binary to packed BCD converter.
// Optional BIN2BCD_AUTOSTART_EN: also start in IDLE whenever bin_in differs from the last converted value.
module bin2bcd_seq #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input logic          clk,
  input logic          reset,
  bin2bcd_seq_if.slave bus
);
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  function automatic logic [127:0] pow10(input int n);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i < n; i++) p = p * 128'd10;
    return p;
  endfunction

  if (pow10(DIGITS) <= ((128'd1 << IN_WIDTH) - 128'd1)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for IN_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]        scr_q, scr_d, bcd_q, bcd_d, adj;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 go;

`ifdef BIN2BCD_AUTOSTART_EN
  logic [IN_WIDTH-1:0]  last_q, last_d;
  assign go = bus.start || (bus.bin_in != last_q);
`else
  assign go = bus.start;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
`ifdef BIN2BCD_AUTOSTART_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
`ifdef BIN2BCD_AUTOSTART_EN
      last_q  <= last_d;
`endif
    end
  end

  // Digits are corrected independently; each +3 stays within its own nibble.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = (scr_q[4*i+:4] >= 4'd5) ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
`ifdef BIN2BCD_AUTOSTART_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: if (go) begin
        state_d = SHIFT;
        bin_d   = bus.bin_in;
        scr_d   = '0;
        cnt_d   = '0;
`ifdef BIN2BCD_AUTOSTART_EN
        last_d  = bus.bin_in;
`endif
      end
      SHIFT: begin
        {scr_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(IN_WIDTH - 1)) begin
          state_d = DONE;
          bcd_d   = scr_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.bcd_out = bcd_q;
endmodule
